frame_reader: RTL and testbench

//   Read-side scan-out stage directly downstream of the frame buffer memory (data_mem).
//   On start, walks the frame sequentially, drives the memory read port (rd_en/rd_addr),

---
 rtl/frame_reader_if.sv | 24 ++
 rtl/frame_reader.sv | 133 +++++++++++++
 tb/tb_frame_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_reader_if.sv
// Frame reader buses: memory read port toward data_mem and the pixel stream toward the sink.
interface frame_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;

  modport master (
    output rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/frame_reader.sv
// Frame scan-out: walks the frame buffer sequentially, issues credit-limited reads and
// streams pixels tagged with sof/eol through a 4-entry FIFO.
module frame_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int H_RES      = 4,
  parameter int V_RES      = 2,
  parameter int BASE_ADDR  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  frame_reader_if.master bus
);
  localparam int DEPTH  = 4;
  localparam int STAGES = 1;
  localparam int XW     = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW     = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
  } pix_t;

  state_t                  state;
  logic [XW-1:0]           x, nx;
  logic [YW-1:0]           y;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  // [0]: read on the bus this cycle, [1]: read whose data arrives this cycle
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][1:0]    tag_pipe;

  pix_t                    fifo [DEPTH];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              occ, fill, commit;
  logic                    push, pop, valid, credit, drained;
  logic                    x_last, y_last, nx_eol;
  pix_t                    head;

  assign push    = vld_pipe[STAGES];
  assign valid   = (occ != 3'd0);
  assign pop     = valid && bus.pix_ready;
  // occupancy after this edge, then plus the read already on the bus
  assign fill    = occ + {2'b0, push} - {2'b0, pop};
  assign commit  = fill + {2'b0, vld_pipe[0]};
  assign credit  = commit < 3'(DEPTH);
  assign drained = (fill == 3'd0) && !vld_pipe[0];

  assign x_last  = (x == XW'(H_RES - 1));
  assign y_last  = (y == YW'(V_RES - 1));
  assign nx      = x_last ? '0 : x + 1'b1;
  assign nx_eol  = (nx == XW'(H_RES - 1));

  assign head          = fifo[rd_ptr];
  assign bus.rd_en     = vld_pipe[0];
  assign bus.rd_addr   = rd_addr;
  assign bus.pix_valid = valid;
  assign bus.pix_data  = valid ? head.data : '0;
  assign bus.pix_sof   = valid & head.sof;
  assign bus.pix_eol   = valid & head.eol;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      rd_addr  <= ADDR_WIDTH'(BASE_ADDR);
      x        <= '0;
      y        <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[1] <= vld_pipe[0];
      tag_pipe[1] <= tag_pipe[0];
      vld_pipe[0] <= 1'b0;
      case (state)
        IDLE: begin
          // the done cycle is still IDLE, so a start there is dropped
          if (start && !done) begin
            state       <= FETCH;
            busy        <= 1'b1;
            vld_pipe[0] <= 1'b1;
            tag_pipe[0] <= {1'b1, (H_RES == 1)};
            rd_addr     <= ADDR_WIDTH'(BASE_ADDR);
            x           <= '0;
            y           <= '0;
          end
        end
        FETCH: begin
          if (x_last && y_last) begin
            state <= DRAIN;
          end else if (credit) begin
            vld_pipe[0] <= 1'b1;
            tag_pipe[0] <= {1'b0, nx_eol};
            rd_addr     <= rd_addr + 1'b1;
            x           <= nx;
            if (x_last) y <= y + 1'b1;
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {bus.rd_data, tag_pipe[STAGES]};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= fill;
    end
  end
endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: main 4x2 instance plus a 1x3 instance at BASE_ADDR=5.
module tb_frame_reader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, start1 = 1'b0;
  logic busy, done, busy1, done1;
  int   pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  frame_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus0 ();
  frame_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus1 ();

  frame_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .H_RES(4), .V_RES(2), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus0));

  frame_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .H_RES(1), .V_RES(3), .BASE_ADDR(5)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(bus1));

  // frame buffer model: word at addr a is a+1, one-cycle read latency
  logic [7:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
  always @(posedge clk) if (bus0.rd_en) bus0.rd_data <= mem[bus0.rd_addr];
  always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= mem[bus1.rd_addr];

  localparam int LOGN = 40;
  logic       lv [LOGN], ls [LOGN], le [LOGN], lre [LOGN], lb [LOGN], ldn [LOGN], lr [LOGN];
  logic [7:0] ld [LOGN];
  logic [2:0] lra [LOGN];
  logic [7:0] bd [32];
  logic       bs [32], be [32];

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return !(c >= 2 && c <= 12);
      2:       return (c % 2) == 1;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic start_for(input int mode, input int c);
    if (mode == 3) return (c == 0 || c == 4 || c == 9 || c == 11 || c == 12);
    return c == 0;
  endfunction

  // entered on a negedge; cycle c is the clock period containing the c-th negedge
  task automatic run(input int mode, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start          = start_for(mode, c);
      bus0.pix_ready = ready_for(mode, c);
      lr[c]  = bus0.pix_ready;
      lv[c]  = bus0.pix_valid;
      ld[c]  = bus0.pix_data;
      ls[c]  = bus0.pix_sof;
      le[c]  = bus0.pix_eol;
      lre[c] = bus0.rd_en;
      lra[c] = bus0.rd_addr;
      lb[c]  = busy;
      ldn[c] = done;
      @(negedge clk);
    end
    start = 1'b0;
    bus0.pix_ready = 1'b1;
  endtask

  task automatic extract(input int ncyc, output int nb, output int nd, output int nr);
    nb = 0; nd = 0; nr = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (lv[c] && lr[c] && nb < 32) begin
        bd[nb] = ld[c]; bs[nb] = ls[c]; be[nb] = le[c];
        nb++;
      end
      if (ldn[c]) nd++;
      if (lre[c]) nr++;
    end
  endtask

  task automatic test_reset;
    logic [15:0] got;
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      @(negedge clk);
      got = {busy, done, bus0.rd_en, bus0.rd_addr, bus0.pix_valid, bus0.pix_data, bus0.pix_sof, bus0.pix_eol};
      total_cnt++;
      if (got !== 16'h0000) $display("FAIL reset_outputs cycle %0d: got %h want 0000", c, got);
      else pass_cnt++;
    end
    total_cnt++;
    if ({bus1.rd_en, bus1.rd_addr} !== 4'b0101)
      $display("FAIL reset_base_addr: got %b want 0101", {bus1.rd_en, bus1.rd_addr});
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream;
    int nb, nd, nr, cont, aerr, k;
    run(0, 16);
    extract(16, nb, nd, nr);
    total_cnt++;
    if ({lre[0], lb[0], lre[1], lra[1], lb[1]} !== 7'b00_1_000_1)
      $display("FAIL stream_first_issue: got %b want 0010001", {lre[0], lb[0], lre[1], lra[1], lb[1]});
    else pass_cnt++;
    total_cnt++;
    if ({lv[2], lv[3], ls[3]} !== 3'b011) $display("FAIL stream_latency: got %b want 011", {lv[2], lv[3], ls[3]});
    else pass_cnt++;
    cont = 0;
    for (int c = 3; c <= 10; c++) if (lv[c]) cont++;
    total_cnt++;
    if (cont != 8) $display("FAIL stream_continuous: got %0d want 8", cont);
    else pass_cnt++;
    total_cnt++;
    if (nb != 8) $display("FAIL stream_beats: got %0d want 8", nb);
    else pass_cnt++;
    for (int i = 0; i < nb && i < 8; i++) begin
      total_cnt++;
      if ({bd[i], bs[i], be[i]} !== {8'(i + 1), i == 0, i % 4 == 3})
        $display("FAIL stream_beat%0d: got %h/%b/%b want %h/%b/%b", i, bd[i], bs[i], be[i], 8'(i + 1), i == 0, i % 4 == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if ({ldn[11], lb[11], lv[11], lb[10], ldn[10]} !== 5'b10010)
      $display("FAIL stream_done_timing: got %b want 10010", {ldn[11], lb[11], lv[11], lb[10], ldn[10]});
    else pass_cnt++;
    total_cnt++;
    if (nd != 1) $display("FAIL stream_done_count: got %0d want 1", nd);
    else pass_cnt++;
    aerr = 0; k = 0;
    for (int c = 0; c < 16; c++) if (lre[c]) begin
      if (lra[c] != 3'(k)) aerr++;
      k++;
    end
    total_cnt++;
    if (nr != 8 || aerr != 0) $display("FAIL stream_addr_seq: reads %0d bad %0d want 8 and 0", nr, aerr);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int nb, nd, nr, early, hold;
    run(1, 40);
    extract(40, nb, nd, nr);
    early = 0; hold = 0;
    for (int c = 0; c <= 12; c++) if (lre[c]) early++;
    for (int c = 3; c <= 12; c++) if (lv[c] && ld[c] == 8'h01 && ls[c]) hold++;
    total_cnt++;
    if (early != 4) $display("FAIL bp_credit_limit: got %0d reads want 4", early);
    else pass_cnt++;
    total_cnt++;
    if (hold != 10) $display("FAIL bp_head_hold: got %0d want 10", hold);
    else pass_cnt++;
    total_cnt++;
    if ({lre[8], lra[8]} !== 4'b0011) $display("FAIL bp_addr_hold: got %b want 0011", {lre[8], lra[8]});
    else pass_cnt++;
    total_cnt++;
    if (nb != 8 || nr != 8) $display("FAIL bp_counts: beats %0d reads %0d want 8 and 8", nb, nr);
    else pass_cnt++;
    for (int i = 0; i < nb && i < 8; i++) begin
      total_cnt++;
      if ({bd[i], bs[i], be[i]} !== {8'(i + 1), i == 0, i % 4 == 3})
        $display("FAIL bp_beat%0d: got %h/%b/%b want %h/%b/%b", i, bd[i], bs[i], be[i], 8'(i + 1), i == 0, i % 4 == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (nd != 1) $display("FAIL bp_done_count: got %0d want 1", nd);
    else pass_cnt++;
  endtask

  task automatic test_toggle;
    int nb, nd, nr, unstable;
    run(2, 40);
    extract(40, nb, nd, nr);
    unstable = 0;
    for (int c = 0; c < LOGN - 1; c++)
      if (lv[c] && !lr[c] && {lv[c + 1], ld[c + 1], ls[c + 1], le[c + 1]} !== {1'b1, ld[c], ls[c], le[c]}) unstable++;
    total_cnt++;
    if (nb != 8) $display("FAIL toggle_beats: got %0d want 8", nb);
    else pass_cnt++;
    for (int i = 0; i < nb && i < 8; i++) begin
      total_cnt++;
      if ({bd[i], bs[i], be[i]} !== {8'(i + 1), i == 0, i % 4 == 3})
        $display("FAIL toggle_beat%0d: got %h/%b/%b want %h/%b/%b", i, bd[i], bs[i], be[i], 8'(i + 1), i == 0, i % 4 == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (unstable != 0) $display("FAIL toggle_stable: got %0d changes want 0", unstable);
    else pass_cnt++;
    total_cnt++;
    if (nd != 1) $display("FAIL toggle_done_count: got %0d want 1", nd);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    int nb, nd, nr, bad;
    run(3, 30);
    extract(30, nb, nd, nr);
    total_cnt++;
    if (nb != 16 || nr != 16) $display("FAIL restart_counts: beats %0d reads %0d want 16 and 16", nb, nr);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < nb && i < 16; i++)
      if ({bd[i], bs[i], be[i]} !== {8'(i % 8 + 1), i % 8 == 0, i % 4 == 3}) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL restart_order: got %0d wrong beats want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (nd != 2 || {ldn[11], ldn[23]} !== 2'b11) $display("FAIL restart_done: count %0d at11/23 %b want 2 and 11", nd, {ldn[11], ldn[23]});
    else pass_cnt++;
    total_cnt++;
    if ({lre[12], lre[13], lra[13], lv[14], lv[15], ls[15]} !== 8'b01_000_011)
      $display("FAIL restart_second_frame: got %b want 01000011", {lre[12], lre[13], lra[13], lv[14], lv[15], ls[15]});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int nb, nd, nr, leak;
    logic [15:0] got;
    run(0, 6);
    extract(6, nb, nd, nr);
    total_cnt++;
    if (nb != 3) $display("FAIL rmid_pre_beats: got %0d want 3", nb);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    got = {busy, done, bus0.rd_en, bus0.rd_addr, bus0.pix_valid, bus0.pix_data, bus0.pix_sof, bus0.pix_eol};
    total_cnt++;
    if (got !== 16'h0000) $display("FAIL rmid_async_clear: got %h want 0000", got);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    leak = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus0.pix_valid || busy || bus0.rd_en) leak++;
    end
    total_cnt++;
    if (leak != 0) $display("FAIL rmid_no_partial: got %0d active cycles want 0", leak);
    else pass_cnt++;
    run(0, 16);
    extract(16, nb, nd, nr);
    total_cnt++;
    if (nb != 8 || nd != 1) $display("FAIL rmid_restart_counts: beats %0d done %0d want 8 and 1", nb, nd);
    else pass_cnt++;
    total_cnt++;
    if ({bd[0], bs[0], be[0]} !== {8'h01, 1'b1, 1'b0})
      $display("FAIL rmid_restart_first: got %h/%b/%b want 01/1/0", bd[0], bs[0], be[0]);
    else pass_cnt++;
  endtask

  task automatic test_single_column;
    logic [7:0] d [3];
    logic       s [3], e [3];
    int         nb, nd, done_at, first_rd;
    nb = 0; nd = 0; done_at = -1; first_rd = -1;
    for (int c = 0; c < 10; c++) begin
      start1 = (c == 0);
      if (bus1.pix_valid && nb < 3) begin
        d[nb] = bus1.pix_data; s[nb] = bus1.pix_sof; e[nb] = bus1.pix_eol;
        nb++;
      end
      if (done1) begin nd++; done_at = c; end
      if (bus1.rd_en && first_rd < 0) first_rd = c * 8 + int'(bus1.rd_addr);
      @(negedge clk);
    end
    start1 = 1'b0;
    total_cnt++;
    if (first_rd != 13) $display("FAIL h1_first_read: got cycle*8+addr %0d want 13", first_rd);
    else pass_cnt++;
    total_cnt++;
    if (nb != 3) $display("FAIL h1_beats: got %0d want 3", nb);
    else pass_cnt++;
    for (int i = 0; i < nb; i++) begin
      total_cnt++;
      if ({d[i], s[i], e[i]} !== {8'(i + 6), i == 0, 1'b1})
        $display("FAIL h1_beat%0d: got %h/%b/%b want %h/%b/1", i, d[i], s[i], e[i], 8'(i + 6), i == 0);
      else pass_cnt++;
    end
    total_cnt++;
    if (nd != 1 || done_at != 6) $display("FAIL h1_done: count %0d at %0d want 1 at 6", nd, done_at);
    else pass_cnt++;
  endtask

  initial begin
    bus0.pix_ready = 1'b1;
    bus1.pix_ready = 1'b1;
    @(negedge clk);
    test_reset;
    test_stream;
    repeat (2) @(negedge clk);
    test_backpressure;
    repeat (2) @(negedge clk);
    test_toggle;
    repeat (2) @(negedge clk);
    test_start_ignored;
    repeat (2) @(negedge clk);
    test_reset_mid;
    repeat (2) @(negedge clk);
    test_single_column;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
